// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit owning HI/LO; long ops run for a fixed cycle count while busy is high.
// Optional build macro MULDIV_MADD_EN enables madd/maddu (op 7/8) accumulating into {HI,LO}.
module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

`ifdef MULDIV_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r;
    state_t             state_s;
    logic               launch_s;
    logic               done_s;
    logic               long_op_s;
    logic               is_div_s;
    logic               is_mac_s;
    logic               div_zero_s;
    logic [CNT_W-1:0]   load_s;
    logic [63:0]        temp_s;
    logic [31:0]        a_abs_s;
    logic [31:0] b_abs_s;
    logic [31:0]        quo_mag_s;
    logic [31:0]        rem_mag_s;
    logic [31:0]        udiv_b_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [63:0]        temp_r;
    logic               commit_r;
    logic               acc_r;
    logic               busy_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;

    // Classify the incoming op and pick its busy length
    always_comb begin
        long_op_s = 1'b0;
        is_div_s  = 1'b0;
        is_mac_s  = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: long_op_s = 1'b1;
            OP_DIV, OP_DIVU: begin
                long_op_s = 1'b1;
                is_div_s  = 1'b1;
            end
            OP_MADD, OP_MADDU: begin
                long_op_s = MADD_EN;
                is_mac_s  = MADD_EN;
            end
            default: long_op_s = 1'b0;
        endcase
        div_zero_s = is_div_s && (B == 32'd0);
        if (is_div_s) begin
            load_s = CNT_W'(DIV_CYCLES - 1);
        end else begin
            load_s = CNT_W'(MULT_CYCLES - 1);
        end
    end

    // Result datapath: divides use sign-magnitude so INT_MIN / -1 wraps to INT_MIN with remainder 0
    always_comb begin
        a_abs_s  = A[31] ? (~A + 32'd1) : A;
        b_abs_s  = B[31] ? (~B + 32'd1) : B;
        if (b_abs_s == 32'd0) begin
            quo_mag_s = 32'd0;
            rem_mag_s = 32'd0;
        end else begin
            quo_mag_s = a_abs_s / b_abs_s;
            rem_mag_s = a_abs_s % b_abs_s;
        end
        udiv_b_s = (B == 32'd0) ? 32'd1 : B;
        case (op)
            OP_MULT, OP_MADD:
                temp_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            OP_MULTU, OP_MADDU:
                temp_s = {32'd0, A} * {32'd0, B};
            OP_DIV: begin
                temp_s[63:32] = A[31] ? (~rem_mag_s + 32'd1) : rem_mag_s;
                temp_s[31:0]  = (A[31] ^ B[31]) ? (~quo_mag_s + 32'd1) : quo_mag_s;
            end
            OP_DIVU:
                temp_s = {A % udiv_b_s, A / udiv_b_s};
            default:
                temp_s = 64'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: launch from IDLE, retire when the countdown reaches zero
    always_comb begin
        state_s  = state_r;
        launch_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && long_op_s) begin
                    state_s  = ST_RUN;
                    launch_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Countdown, pending result and HI/LO write-back
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            temp_r   <= 64'd0;
            commit_r <= 1'b0;
            acc_r    <= 1'b0;
            busy_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            if (launch_s) begin
                temp_r   <= temp_s;
                cnt_r    <= load_s;
                commit_r <= !div_zero_s;
                acc_r    <= is_mac_s;
            end else if (done_s) begin
                if (commit_r && acc_r) begin
                    {hi_r, lo_r} <= {hi_r, lo_r} + temp_r;
                end else if (commit_r) begin
                    {hi_r, lo_r} <= temp_r;
                end
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (op == OP_MTHI) begin
                hi_r <= A;
            end else if (op == OP_MTLO) begin
                lo_r <= A;
            end
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; expected HI/LO are queued at issue and popped at completion.
// Build with +define+MULDIV_MADD_EN to exercise madd/maddu.
module tb_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb[$];

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] a, input logic st);
        start = st; op = o; A = a; B = 32'd0;
        step();
        start = 1'b0; op = 4'd0;
        if (o == 4'd5) m_hi = a; else m_lo = a;
        chk("mt_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ncyc, input int glitch);
        int n;
        logic [63:0] exp;
        sb.push_back({eh, el});
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 4'd0;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hi_while_busy"}, HI, m_hi);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == glitch) begin
                start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd3;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            step();
        end
        start = 1'b0; op = 4'd0;
        chk({tag, "_busy_cycles"}, n, ncyc);
        exp = sb.pop_front();
        chk({tag, "_hi"}, HI, exp[63:32]);
        chk({tag, "_lo"}, LO, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        Reset = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        step(); step();
        Reset = 1'b1;
        step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        // mthi/mtlo, including op 5 with start asserted
        move_to(4'd5, 32'h0000_1234, 1'b0);
        move_to(4'd6, 32'h0000_5678, 1'b0);
        move_to(4'd5, 32'h0BAD_CAFE, 1'b1);

        // signed and unsigned multiply
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0);

        // divides, including zero divisor and INT_MIN / -1
        run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, m_hi, m_lo, 10, 0);
        run_op("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 0);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);
        run_op("divu_big", 4'd4, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 10, 0);

        // mtlo immediately followed by mult: mult result overwrites both
        move_to(4'd6, 32'h0000_AAAA, 1'b0);
        run_op("mult_b2b", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 0);

        // start re-pulsed on cycle 2 of a mult is ignored
        run_op("mult_restart", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 2);

        // start with a non-long op does nothing
        start = 1'b1; op = 4'd0; A = 32'h1111_1111; B = 32'h2;
        step();
        start = 1'b0;
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_lo", LO, m_lo);

`ifdef MULDIV_MADD_EN
        move_to(4'd5, 32'd0, 1'b0);
        move_to(4'd6, 32'hFFFF_FFFF, 1'b0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
        run_op("madd", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 5, 0);
`else
        start = 1'b1; op = 4'd8; A = 32'd1; B = 32'd1;
        step();
        start = 1'b0; op = 4'd0;
        chk("op8_busy", {31'd0, busy}, 32'd0);
        step(); step(); step(); step(); step();
        chk("op8_hi", HI, m_hi);
        chk("op8_lo", LO, m_lo);
`endif

        // reset asserted on cycle 4 of a divide
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        step();
        start = 1'b0; op = 4'd0;
        step(); step(); step();
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
        end
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", HI, 32'd0);
        chk("rst_after_lo", LO, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
